bcd_stopwatch: RTL

//  Upstream source for the 4-digit multiplexed 7-seg display: a start/pause/clear

---
 rtl/stopwatch_pkg.sv | 32 +++
 rtl/btn_debounce.sv | 64 ++++++
 rtl/bcd_stopwatch.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types, constants and BCD helper for the stopwatch
//
// Purpose : FSM state type, BCD digit width/limit and a one-digit BCD
//           incrementer used to build the carry chain in bcd_stopwatch.
// Ports   : none (package)
package stopwatch_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;

  // Returns {carry_out, next_digit}. Anything at or above 9 rolls to 0 with a
  // carry, so an out-of-range digit can never persist.
  function automatic logic [BCD_W:0] bcd_inc(input logic [BCD_W-1:0] digit,
                                             input logic             cin);
    logic [BCD_W:0] res;
    if (!cin) begin
      res = {1'b0, digit};
    end else if (digit >= BCD_MAX) begin
      res = {1'b1, {BCD_W{1'b0}}};
    end else begin
      res = {1'b0, digit + BCD_W'(1)};
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser, debouncer and press-pulse generator
//
// Purpose : turns a raw asynchronous active-high button into a single-cycle
//           press pulse. Raw -> 2-FF sync -> stable counter -> debounced
//           level; a rising edge of the debounced level gives o_press.
//           Press-to-pulse-visible latency is DEBOUNCE_CYCLES+2 edges, so the
//           consumer registering the pulse reacts DEBOUNCE_CYCLES+3 edges
//           after the raw rise.
// Ports   : i_clk    in  1  clock
//           i_rst_n  in  1  asynchronous active-low reset
//           i_btn    in  1  raw button
//           o_press  out 1  registered one-cycle pulse per accepted press
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  logic w_differs;
  logic w_settle;

  // r_cnt counts consecutive synced samples that disagree with the current
  // debounced level; the DEBOUNCE_CYCLES-th such sample commits the new level.
  assign w_differs = (r_sync2 != r_level);
  assign w_settle  = w_differs && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      // Pulse is raised on the same edge the level commits high, not one later.
      r_press <= w_settle && r_sync2;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_settle) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/bcd_stopwatch.sv
// rtl/bcd_stopwatch.sv - start/pause/clear BCD stopwatch SS.hh feeding a 4-digit display
//
// Purpose : counts 00.00..99.99 in BCD, one hundredth per CLK_DIV clocks
//           while running. Start button toggles run/pause, clear button
//           returns to idle with zeroed digits. Both buttons debounced.
// Ports   : clk_i        in  1  clock
//           rst_i        in  1  asynchronous active-low reset
//           btn_start_i  in  1  raw start/pause button
//           btn_clear_i  in  1  raw clear button
//           counter_0    out 4  tens of seconds (leftmost digit)
//           counter_1    out 4  units of seconds
//           counter_2    out 4  tenths
//           counter_3    out 4  hundredths
//           running_o    out 1  high while in RUN
//           overflow_o   out 1  sticky, set on 99.99 -> 00.00
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV         = 1_000_000,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             btn_start_i,
  input  logic             btn_clear_i,
  output logic [BCD_W-1:0] counter_0,
  output logic [BCD_W-1:0] counter_1,
  output logic [BCD_W-1:0] counter_2,
  output logic [BCD_W-1:0] counter_3,
  output logic             running_o,
  output logic             overflow_o
);

  localparam int PSC_W = $clog2(CLK_DIV);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CLK_DIV - 1);

  logic w_start_press;
  logic w_clear_press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_start (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_btn   (btn_start_i),
    .o_press (w_start_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_clear (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_btn   (btn_clear_i),
    .o_press (w_clear_press)
  );

  sw_state_e        r_state;
  sw_state_e        w_state_nxt;
  logic             r_running;
  logic             r_overflow;
  logic [PSC_W-1:0] r_psc;
  logic             w_tick;

  logic [BCD_W-1:0] r_dig0;
  logic [BCD_W-1:0] r_dig1;
  logic [BCD_W-1:0] r_dig2;
  logic [BCD_W-1:0] r_dig3;
  logic [BCD_W:0]   w_inc0;
  logic [BCD_W:0]   w_inc1;
  logic [BCD_W:0]   w_inc2;
  logic [BCD_W:0]   w_inc3;

  // Clear has priority; a start pulse in the same cycle is dropped.
  always_comb begin
    w_state_nxt = r_state;
    if (w_clear_press) begin
      w_state_nxt = IDLE;
    end else if (w_start_press) begin
      case (r_state)
        IDLE:    w_state_nxt = RUN;
        RUN:     w_state_nxt = PAUSE;
        PAUSE:   w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
    end
  end

  // The prescaler advances on every edge where the current state is RUN,
  // including the edge that leaves RUN; in PAUSE it simply holds, so the
  // partial tick survives a pause/resume.
  assign w_tick = (r_state == RUN) && (r_psc == PSC_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_psc <= '0;
    end else if (w_clear_press) begin
      r_psc <= '0;
    end else if (r_state == RUN) begin
      r_psc <= w_tick ? '0 : r_psc + PSC_W'(1);
    end
  end

  // Ripple carry from hundredths up to tens of seconds.
  assign w_inc3 = bcd_inc(r_dig3, w_tick);
  assign w_inc2 = bcd_inc(r_dig2, w_inc3[BCD_W]);
  assign w_inc1 = bcd_inc(r_dig1, w_inc2[BCD_W]);
  assign w_inc0 = bcd_inc(r_dig0, w_inc1[BCD_W]);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_dig0     <= '0;
      r_dig1     <= '0;
      r_dig2     <= '0;
      r_dig3     <= '0;
      r_overflow <= 1'b0;
    end else if (w_clear_press) begin
      r_dig0     <= '0;
      r_dig1     <= '0;
      r_dig2     <= '0;
      r_dig3     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_dig0 <= w_inc0[BCD_W-1:0];
      r_dig1 <= w_inc1[BCD_W-1:0];
      r_dig2 <= w_inc2[BCD_W-1:0];
      r_dig3 <= w_inc3[BCD_W-1:0];
      // Carry out of the top digit means 99.99 wrapped to 00.00.
      if (w_inc0[BCD_W]) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign counter_0  = r_dig0;
  assign counter_1  = r_dig1;
  assign counter_2  = r_dig2;
  assign counter_3  = r_dig3;
  assign running_o  = r_running;
  assign overflow_o = r_overflow;

endmodule
